// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// over a shared memory with a req/ready handshake and drives all datapath controls.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       i_or_d,
  output logic [1:0] mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_sel,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [2:0] state,
  output logic       illegal_op,
  output logic       mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic          is_r, r_ok, is_lw, is_lh, is_lhu, is_sw, is_beq;
  logic          is_addi, is_andi, is_ori, is_load, is_imm, legal, timeout;
  logic [2:0]    r_sel;

  always_comb begin
    r_ok  = 1'b1;
    r_sel = 3'd0;
    case (funct)
      6'b100000: r_sel = 3'd0;
      6'b100010: r_sel = 3'd1;
      6'b000000: r_sel = 3'd2;
      6'b000010: r_sel = 3'd3;
      6'b100100: r_sel = 3'd4;
      6'b100101: r_sel = 3'd5;
      6'b101010: r_sel = 3'd6;
      6'b101011: r_sel = 3'd7;
      default:   r_ok  = 1'b0;
    endcase
  end

  assign is_r    = (opcode == 6'b000000);
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_beq  = (opcode == 6'b000100);
  assign is_lh   = (opcode == 6'b100001);
  assign is_lhu  = (opcode == 6'b100101);
  assign is_addi = (opcode == 6'b001000);
  assign is_andi = (opcode == 6'b001100);
  assign is_ori  = (opcode == 6'b001101);
  assign is_load = is_lw | is_lh | is_lhu;
  assign is_imm  = is_addi | is_andi | is_ori;
  assign legal   = (is_r & r_ok) | is_load | is_sw | is_beq | is_imm;
  // Last stalled cycle of the window unless memory answers on it.
  assign timeout = (wait_cnt == CW'(MEM_TIMEOUT - 1)) & ~mem_ready;

  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 2'd0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_sel    = 3'd0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 2'd1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (timeout) begin
          mem_err = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        if (legal) nxt = S_EXEC;
        else begin
          illegal_op = 1'b1;
          nxt        = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        nxt       = S_FETCH;
        if (is_r) begin
          alu_sel = r_sel;
          nxt     = S_WB;
        end else if (is_imm) begin
          alu_src_b = 2'd2;
          alu_sel   = is_andi ? 3'd4 : (is_ori ? 3'd5 : 3'd0);
          nxt       = S_WB;
        end else if (is_load | is_sw) begin
          alu_src_b = 2'd2;
          nxt       = S_MEM;
        end else if (is_beq) begin
          alu_sel  = 3'd1;
          pc_src   = 1'b1;
          pc_write = zero;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_read  = is_lw ? 2'd1 : (is_lh ? 2'd2 : (is_lhu ? 2'd3 : 2'd0));
        mem_write = is_sw;
        if (mem_ready) nxt = is_load ? S_WB : S_FETCH;
        else if (timeout) begin
          mem_err = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_load;
        nxt        = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
    // Reset clamps every control output immediately, independent of the clock.
    if (!rst_n) begin
      mem_req    = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 2'd0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_sel    = 3'd0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      mem_err    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur || mem_err) wait_cnt <= '0;
      else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign state = cur;

endmodule
